// File: rtl/ps2_kbd_if.sv
// ---------------------------------------------------------------------------
// if_wb : 32-bit Wishbone bus bundle used by the PS/2 keyboard receiver.
//   cyc, stb, we, sel[3:0], adr[31:0], dat_i[31:0] : master -> slave
//   dat_o[31:0], ack                               : slave -> master
// ---------------------------------------------------------------------------
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;

    modport slave  (input  cyc, stb, we, sel, adr, dat_i, output dat_o, ack);
    modport master (output cyc, stb, we, sel, adr, dat_i, input  dat_o, ack);
endinterface

// File: rtl/ps2_kbd.sv
// ---------------------------------------------------------------------------
// ps2_kbd : PS/2 keyboard receiver with a receive FIFO behind a Wishbone slave.
//
// Ports
//   clk_i    in   system clock, all logic on its rising edge
//   rst_i    in   synchronous active-high reset
//   bus      if_wb.slave  register access (adr[2]=0 DATA, adr[2]=1 STATUS)
//   ps2_clk  in   PS/2 clock pin, asynchronous
//   ps2_dat  in   PS/2 data pin, asynchronous
//   irq      out  FIFO non-empty and IE set
//
// Parameters
//   CLKFREQ     clk_i frequency in Hz; frame timeout is CLKFREQ/1000 cycles
//   FIFO_DEPTH  receive FIFO entries, power of two, 2..256
//
// Build option
//   PS2_PARITY_CHECK_EN : when defined, frames with bad (even) parity set PE
//                         and are not pushed; otherwise parity is ignored.
// ---------------------------------------------------------------------------
module ps2_kbd #(
    parameter int CLKFREQ    = 10000000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    if_wb.slave  bus,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic irq
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int TMO = CLKFREQ / 1000;
    localparam int TW  = $clog2(TMO + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // True when the 9 data+parity bits carry odd parity (a good frame).
    function automatic logic f_odd_parity(input logic [8:0] v);
        return ^v;
    endfunction

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_clk_flt, r_clk_flt_d;
    logic [1:0]    r_flt_cnt;
    logic          w_fall;

    state_t        r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_tmo;
    logic          r_push, r_fe_set, r_pe_set;
    logic [7:0]    r_push_byte;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_ovr, r_pe, r_fe, r_ie, r_ack, r_irq;
    logic [31:0]   r_dat_o, w_rdata;
    logic [8:0]    w_count9;
    logic [7:0]    w_cnt8;
    logic          w_req, w_rd_data, w_st_wr, w_empty, w_full;
    logic          w_pop, w_push_ok, w_ovr_set, w_ie_nxt;
    logic          w_unused;

    assign w_unused = ^{bus.adr[31:3], bus.adr[1:0], bus.sel[3:1],
                        bus.dat_i[31:5], bus.dat_i[0], r_par};

    // Synchronizers and ps2_clk glitch filter (4 consecutive differing samples flip it).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_clk_flt   <= 1'b1;
            r_clk_flt_d <= 1'b1;
            r_flt_cnt   <= 2'd0;
        end else begin
            r_clk_s1    <= ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_dat_s1    <= ps2_dat;
            r_dat_s2    <= r_dat_s1;
            r_clk_flt_d <= r_clk_flt;
            if (r_clk_s2 == r_clk_flt) begin
                r_flt_cnt <= 2'd0;
            end else if (r_flt_cnt == 2'd3) begin
                r_clk_flt <= r_clk_s2;
                r_flt_cnt <= 2'd0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 2'd1;
            end
        end
    end

    assign w_fall = r_clk_flt_d & ~r_clk_flt;

    // Receiver FSM: frame assembly, timeout, and one-cycle push/error pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_par       <= 1'b0;
            r_tmo       <= '0;
            r_push      <= 1'b0;
            r_fe_set    <= 1'b0;
            r_pe_set    <= 1'b0;
            r_push_byte <= 8'h00;
        end else begin
            r_push   <= 1'b0;
            r_fe_set <= 1'b0;
            r_pe_set <= 1'b0;
            if (r_state == S_IDLE) begin
                r_tmo <= '0;
                if (w_fall && !r_dat_s2) begin
                    r_state  <= S_DATA;
                    r_bitcnt <= 3'd0;
                end
            end else if (w_fall) begin
                r_tmo <= '0;
                case (r_state)
                    S_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (!r_dat_s2) begin
                            r_fe_set <= 1'b1;
                        end else begin
`ifdef PS2_PARITY_CHECK_EN
                            if (f_odd_parity({r_par, r_shift})) begin
                                r_push      <= 1'b1;
                                r_push_byte <= r_shift;
                            end else begin
                                r_pe_set <= 1'b1;
                            end
`else
                            r_push      <= 1'b1;
                            r_push_byte <= r_shift;
`endif
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_tmo == TW'(TMO - 1)) begin
                // No clock edge for a whole timeout window: abandon the frame.
                r_tmo    <= '0;
                r_fe_set <= 1'b1;
                r_state  <= S_IDLE;
            end else begin
                r_tmo <= r_tmo + TW'(1'b1);
            end
        end
    end

    // A request is a cyc&stb cycle not already being acknowledged.
    assign w_req     = bus.cyc & bus.stb & ~r_ack;
    assign w_rd_data = w_req & ~bus.we & ~bus.adr[2];
    assign w_st_wr   = w_req & bus.we & bus.adr[2] & bus.sel[0];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = w_rd_data & ~w_empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok = r_push & (~w_full | w_pop);
    assign w_ovr_set = r_push & w_full & ~w_pop;
    assign w_ie_nxt  = w_st_wr ? bus.dat_i[4] : r_ie;
    assign w_count9  = 9'(r_count);
    // A full 256-entry FIFO cannot show 256 in 8 bits; report it saturated.
    assign w_cnt8    = w_count9[8] ? 8'hFF : w_count9[7:0];

    // Next FIFO occupancy.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1'b1);
            2'b01:   w_count_nxt = r_count - CW'(1'b1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Read mux for the register being accessed.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (bus.adr[2]) begin
            w_rdata = {16'h0000, w_cnt8, 3'b000, r_ie, r_fe, r_pe, r_ovr, ~w_empty};
        end else if (!w_empty) begin
            w_rdata = {23'h000000, 1'b1, r_mem[r_rptr]};
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_push_byte;
        end
    end

    // FIFO pointers, status flags, bus response and interrupt.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovr   <= 1'b0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
            r_ie    <= 1'b0;
            r_ack   <= 1'b0;
            r_dat_o <= 32'h0000_0000;
            r_irq   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1'b1);
            end
            r_count <= w_count_nxt;
            // Error sets take priority over a same-cycle write-1-to-clear.
            r_ovr   <= w_ovr_set | (r_ovr & ~(w_st_wr & bus.dat_i[1]));
            r_pe    <= r_pe_set  | (r_pe  & ~(w_st_wr & bus.dat_i[2]));
            r_fe    <= r_fe_set  | (r_fe  & ~(w_st_wr & bus.dat_i[3]));
            r_ie    <= w_ie_nxt;
            r_ack   <= w_req;
            r_dat_o <= (w_req && !bus.we) ? w_rdata : 32'h0000_0000;
            r_irq   <= (w_count_nxt != '0) & w_ie_nxt;
        end
    end

    assign bus.ack   = r_ack;
    assign bus.dat_o = r_dat_o;
    assign irq       = r_irq;

endmodule

// File: doc/ps2_kbd.md
PS2_KBD -- requirements
Module: ps2_kbd

Interface
REQ-001 Parameter CLKFREQ, default 10000000, clk_i frequency in Hz; sets the frame-timeout length.
REQ-002 Parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, range 2..256.
REQ-003 Port clk_i  input  1  system clock; the only clock; all logic on its rising edge.
REQ-004 Port rst_i  input  1  reset; synchronous, active-high.
REQ-005 Port bus  if_wb.slave  --  Wishbone slave; uses cyc, stb, we, sel[3:0], adr (only bit 2 decoded), dat_i[31:0], dat_o[31:0], ack.
REQ-006 Port ps2_clk  input  1  PS/2 clock pin; asynchronous to clk_i.
REQ-007 Port ps2_dat  input  1  PS/2 data pin; asynchronous to clk_i.
REQ-008 Port irq  output  1  high while the FIFO is non-empty and IE=1.

Function
REQ-009 ps2_clk and ps2_dat each pass through a 2-flop synchronizer; ps2_clk then passes a filter that changes its output only after 4 consecutive equal synchronized samples.
REQ-010 A bit is sampled from synchronized ps2_dat on each filtered ps2_clk falling edge.
REQ-011 Receiver FSM states: IDLE, DATA, PARITY, STOP.
REQ-012 IDLE -> DATA on a sampled 0 (start bit); a sampled 1 in IDLE is ignored.
REQ-013 DATA shifts 8 bits LSB-first; the bit counter wraps after bit 7; then -> PARITY.
REQ-014 PARITY captures the bit, then -> STOP.
REQ-015 STOP: a sampled 1 completes the frame; a sampled 0 sets FE, discards the byte, and returns to IDLE.
REQ-016 Frame timeout: in any non-IDLE state, CLKFREQ/1000 clk_i cycles without a filtered falling edge sets FE and forces IDLE.
REQ-017 A completed frame pushes the byte into the FIFO one cycle after the stop-bit sample.
REQ-018 Push while FIFO full: byte dropped, OVR set, FIFO contents unchanged.
REQ-019 Register at adr[2]=0 (DATA), read: dat_o = {23'b0, valid, byte}; valid=1 pops the head; empty read returns 0 and does not pop.
REQ-020 Register at adr[2]=1 (STATUS), read: bit0 NE, bit1 OVR, bit2 PE, bit3 FE, bit4 IE, bits[15:8] FIFO count, all other bits 0.
REQ-021 STATUS write with sel[0]=1: dat_i bits 1..3 written as 1 clear OVR/PE/FE (write-1-to-clear); bit4 loads IE.
REQ-022 DATA writes are acknowledged and have no effect.
REQ-023 ack asserts exactly one cycle after the cycle where cyc&stb are high with ack low; it lasts one cycle; no back-to-back ack; dat_o is valid with ack.
REQ-024 Push and pop in the same cycle: both occur; count unchanged; when full, the push is accepted and no overrun occurs.
REQ-025 An error-set and a W1C in the same cycle: set wins.

Reset
REQ-026 rst_i=1: FSM -> IDLE, filter/synchronizers -> 1, FIFO emptied (count 0), OVR/PE/FE/IE=0, ack=0, dat_o=0, irq=0.
REQ-027 Reset asserted mid-frame discards the partial frame; the next frame is decoded from its start bit.

Configuration
REQ-028 Macro PS2_PARITY_CHECK_EN defined: a frame whose 9 data+parity bits have even parity sets PE and is not pushed.
REQ-029 Macro PS2_PARITY_CHECK_EN undefined: the parity bit is ignored, every stop-valid frame is pushed, and PE reads 0.

Verification
REQ-030 Frame 0x1C with odd parity and valid stop -> STATUS reads 0x0000_0101; DATA reads 0x0000_011C; then STATUS reads 0x0000_0000.
REQ-031 With FIFO_DEPTH=16, 17 frames 0x00..0x10 and no reads -> count 16, OVR=1, 16 DATA reads return 0x00..0x0F in order.
REQ-032 Frame 0x5A with a wrong parity bit -> with the macro: PE=1 and FIFO empty; without the macro: 0x5A is pushed and PE=0.
REQ-033 Frame aborted after 3 data bits, then idle for CLKFREQ/1000+1 cycles -> FE=1 and FSM in IDLE; a following frame 0xF0 is received correctly.
REQ-034 Write STATUS 0x10, then receive one byte -> irq=1; DATA read -> irq=0 on the following cycle; write 0x0E -> flags clear.
